// File: rtl/trace_ctrl_pkg.sv
// trace_ctrl_pkg: shared constants for the trace command controller.
//   - host command opcodes (single-byte commands from the UART receiver)
//   - trace width codes driven to traceIF
//   - reply FSM and transmit arbiter state encodings
package trace_ctrl_pkg;

  // Host command opcodes
  localparam logic [7:0] CMD_W1     = 8'h01;
  localparam logic [7:0] CMD_W2     = 8'h02;
  localparam logic [7:0] CMD_W4     = 8'h03;
  localparam logic [7:0] CMD_EN_OFF = 8'h10;
  localparam logic [7:0] CMD_EN_ON  = 8'h11;
  localparam logic [7:0] CMD_STATUS = 8'h20;

  // Trace width codes (1, 2 and 4 data bits)
  localparam logic [1:0] WIDTH_1 = 2'd1;
  localparam logic [1:0] WIDTH_2 = 2'd2;
  localparam logic [1:0] WIDTH_4 = 2'd3;

  // Status reply sequencer: HDR, STAT, WID bytes
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HDR  = 2'd1,
    R_STAT = 2'd2,
    R_WID  = 2'd3
  } reply_state_e;

  // Transmit arbiter: HOLD covers the cycle the UART needs to drop txFree
  typedef enum logic {
    T_IDLE = 1'b0,
    T_HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/trace_cmd_decode.sv
// trace_cmd_decode: combinational host command decoder.
//   rxByte_i/rxStrobe_i : received byte and its one-cycle valid pulse
//   setWidth_o/widthVal_o : width update strobe and the new width code
//   setEn_o/clrEn_o     : trace enable set/clear strobes
//   statusReq_o         : status reply request strobe
// Strobes are high only in the rxStrobe cycle; unknown opcodes produce nothing.
module trace_cmd_decode
  import trace_ctrl_pkg::*;
(
  input  logic [7:0] rxByte_i,
  input  logic       rxStrobe_i,
  output logic       setWidth_o,
  output logic [1:0] widthVal_o,
  output logic       setEn_o,
  output logic       clrEn_o,
  output logic       statusReq_o
);

  always_comb begin
    setWidth_o  = 1'b0;
    widthVal_o  = WIDTH_2;
    setEn_o     = 1'b0;
    clrEn_o     = 1'b0;
    statusReq_o = 1'b0;
    if (rxStrobe_i) begin
      case (rxByte_i)
        CMD_W1:     begin setWidth_o = 1'b1; widthVal_o = WIDTH_1; end
        CMD_W2:     begin setWidth_o = 1'b1; widthVal_o = WIDTH_2; end
        CMD_W4:     begin setWidth_o = 1'b1; widthVal_o = WIDTH_4; end
        CMD_EN_OFF: clrEn_o     = 1'b1;
        CMD_EN_ON:  setEn_o     = 1'b1;
        CMD_STATUS: statusReq_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trace_ctrl.sv
// trace_ctrl: trace path command controller and UART transmit arbiter.
//   clkOut, rst            : 48 MHz clock, synchronous active-high reset
//   rxByte/rxStrobe/rxErr  : UART receiver byte, valid pulse, framing error
//   sync, overflow         : traceIF in-sync level, packSend overflow level
//   pktReady/pktData/pktNext : packSend byte stream handshake
//   txFree/txStart/txByte  : shared UART transmitter handshake
//   width, traceEn         : configuration outputs to traceIF
// Optional feature macro TRACE_CTRL_ACK_EN: each set/enable command queues
// one ACK_BYTE reply (1-deep, merged), sent ahead of a starting status reply.
module trace_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_WIDTH = 2'd2,
  parameter logic [7:0] STATUS_HDR  = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'hAC
) (
  input  logic       clkOut,
  input  logic       rst,
  input  logic [7:0] rxByte,
  input  logic       rxStrobe,
  input  logic       rxErr,
  input  logic       sync,
  input  logic       overflow,
  input  logic       pktReady,
  input  logic [7:0] pktData,
  output logic       pktNext,
  input  logic       txFree,
  output logic       txStart,
  output logic [7:0] txByte,
  output logic [1:0] width,
  output logic       traceEn
);

  logic       setWidth, setEn, clrEn, statusReq;
  logic [1:0] widthVal;

  trace_cmd_decode u_dec (
    .rxByte_i    (rxByte),
    .rxStrobe_i  (rxStrobe),
    .setWidth_o  (setWidth),
    .widthVal_o  (widthVal),
    .setEn_o     (setEn),
    .clrEn_o     (clrEn),
    .statusReq_o (statusReq)
  );

  reply_state_e rstate_q, rstate_d;
  tx_state_e    tstate_q, tstate_d;
  logic [1:0]   width_q, width_d;
  logic         en_q, en_d;
  logic         errS_q, errS_d;
  logic         ovfS_q, ovfS_d;
  logic         txStart_q, txStart_d;
  logic         pktNext_q, pktNext_d;
  logic [7:0]   txByte_q, txByte_d;
  logic         issueStat;
  logic [7:0]   statByte;

`ifdef TRACE_CTRL_ACK_EN
  logic ackPend_q, ackPend_d;
  logic ackIssue;
`else
  // Ack reply byte has no user in this build.
  logic unused_ackByte;
  assign unused_ackByte = ^ACK_BYTE;
`endif

  assign statByte = {4'b0, errS_q, ovfS_q, sync, en_q};

  // Decisions are made in T_IDLE and registered, so txStart/pktNext/txByte
  // appear one cycle later as clean register outputs. That register stage is
  // what sets the 2-cycle reply latency and the 1-byte-per-2-cycles rate.
  always_comb begin
    rstate_d  = rstate_q;
    tstate_d  = tstate_q;
    width_d   = width_q;
    en_d      = en_q;
    txStart_d = 1'b0;
    pktNext_d = 1'b0;
    txByte_d  = txByte_q;
    issueStat = 1'b0;
`ifdef TRACE_CTRL_ACK_EN
    ackIssue  = 1'b0;
`endif

    if (setWidth) width_d = widthVal;
    if (setEn)      en_d = 1'b1;
    else if (clrEn) en_d = 1'b0;

    // A status request while a reply is in flight is dropped.
    if (statusReq && rstate_q == R_IDLE) rstate_d = R_HDR;

    case (tstate_q)
      T_IDLE: begin
        if (txFree) begin
`ifdef TRACE_CTRL_ACK_EN
          // Ack may only go out before HDR, never between reply bytes.
          if (ackPend_q && (rstate_q == R_IDLE || rstate_q == R_HDR)) begin
            ackIssue  = 1'b1;
            txByte_d  = ACK_BYTE;
            txStart_d = 1'b1;
            tstate_d  = T_HOLD;
          end else
`endif
          if (rstate_q != R_IDLE) begin
            txStart_d = 1'b1;
            tstate_d  = T_HOLD;
            case (rstate_q)
              R_HDR: begin
                txByte_d = STATUS_HDR;
                rstate_d = R_STAT;
              end
              R_STAT: begin
                txByte_d  = statByte;
                issueStat = 1'b1;
                rstate_d  = R_WID;
              end
              default: begin
                txByte_d = {6'b0, width_q};
                rstate_d = R_IDLE;
              end
            endcase
          end else if (pktReady) begin
            txByte_d  = pktData;
            txStart_d = 1'b1;
            pktNext_d = 1'b1;
            tstate_d  = T_HOLD;
          end
        end
      end
      default: tstate_d = T_IDLE;
    endcase

    // Clear on STAT issue, but a same-cycle set event keeps the flag.
    errS_d = (errS_q & ~issueStat) | rxErr;
    ovfS_d = (ovfS_q & ~issueStat) | overflow;
`ifdef TRACE_CTRL_ACK_EN
    ackPend_d = (ackPend_q & ~ackIssue) | setWidth | setEn | clrEn;
`endif
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      tstate_q  <= T_IDLE;
      width_q   <= RESET_WIDTH;
      en_q      <= 1'b1;
      errS_q    <= 1'b0;
      ovfS_q    <= 1'b0;
      txStart_q <= 1'b0;
      pktNext_q <= 1'b0;
      txByte_q  <= 8'h00;
`ifdef TRACE_CTRL_ACK_EN
      ackPend_q <= 1'b0;
`endif
    end else begin
      rstate_q  <= rstate_d;
      tstate_q  <= tstate_d;
      width_q   <= width_d;
      en_q      <= en_d;
      errS_q    <= errS_d;
      ovfS_q    <= ovfS_d;
      txStart_q <= txStart_d;
      pktNext_q <= pktNext_d;
      txByte_q  <= txByte_d;
`ifdef TRACE_CTRL_ACK_EN
      ackPend_q <= ackPend_d;
`endif
    end
  end

  assign txStart = txStart_q;
  assign pktNext = pktNext_q;
  assign txByte  = txByte_q;
  assign width   = width_q;
  assign traceEn = en_q;

endmodule
